adc_serial_capture: RTL and testbench

- Serial-ADC front end directly downstream of the clock generator in the signal-capture path.
- Runs on CLOCK_50. Derives the ADC serial clock (SCLK) and active-low chip select. Shifts in one conversion frame per cycle of operation.
- Presents each captured sample on a one-deep valid/ready output register to the sample consumer.
- Captures continuously while capture_en is high.

---
 rtl/adc_serial_capture.sv | 151 +++++++++++++++
 tb/tb_adc_serial_capture.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_capture.sv
// Serial-ADC capture front end: generates SCLK/CS_n, shifts in one frame per cycle of
// operation and presents each sample on a one-deep valid/ready register.
module adc_serial_capture #(
  parameter int HALF_DIV    = 2,
  parameter int LEAD_BITS   = 4,
  parameter int SAMPLE_BITS = 12,
  parameter int QUIET_CYC   = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic                   capture_en,
  input  logic                   adc_sdo,
  output logic                   adc_sclk,
  output logic                   adc_cs_n,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun,
  input  logic                   clr_overrun,
  output logic [15:0]            frame_count
);

  // state   | meaning
  // S_IDLE  | cs_n high, sclk high, waiting for capture_en
  // S_SETUP | cs_n low, one half-period before the first SCLK falling edge
  // S_SHIFT | SCLK toggles each tick, sdo sampled on rising edges
  // S_QUIET | cs_n high for QUIET_CYC cycles between frames

  localparam int               FRAME      = LEAD_BITS + SAMPLE_BITS;
  localparam int               BW         = $clog2(FRAME + 1);
  localparam logic [7:0]       DIV_LOAD   = 8'(HALF_DIV - 1);
  localparam logic [7:0]       QUIET_LOAD = 8'(QUIET_CYC - 1);
  localparam logic [BW-1:0]    LAST_BIT   = BW'(FRAME - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_QUIET} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_div;
  logic [7:0]             r_quiet;
  logic [BW-1:0]          r_bit;
  logic [SAMPLE_BITS-1:0] r_shift;
  logic                   r_sclk;
  logic                   r_done;
  logic                   r_valid;
  logic                   r_overrun;
  logic [SAMPLE_BITS-1:0] r_data;
  logic [15:0]            r_frame_cnt;
  logic                   w_cs_n;
  logic                   w_running;
  logic                   w_tick;
  logic                   w_rise;
  logic                   w_last_rise;
  logic                   w_load;

  assign w_running   = (r_state == S_SETUP) || (r_state == S_SHIFT);
  assign w_tick      = w_running && (r_div == 8'd0);
  assign w_rise      = (r_state == S_SHIFT) && w_tick && !r_sclk;
  assign w_last_rise = w_rise && (r_bit == LAST_BIT);
  assign w_load      = !r_valid || sample_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cs_n      = 1'b1;
    case (r_state)
      S_IDLE:  if (capture_en) w_state_nxt = S_SETUP;
      S_SETUP: begin
        w_cs_n = 1'b0;
        if (w_tick) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_cs_n = 1'b0;
        if (w_last_rise) w_state_nxt = S_QUIET;
      end
      S_QUIET: if (r_quiet == 8'd0) w_state_nxt = capture_en ? S_SETUP : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Divider reloads on entry to SETUP and on every tick; parked at zero otherwise.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_div <= 8'd0;
    end else if (w_state_nxt == S_SETUP || w_state_nxt == S_SHIFT) begin
      if (!w_running || w_tick) r_div <= DIV_LOAD;
      else                      r_div <= r_div - 8'd1;
    end else begin
      r_div <= 8'd0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn)                r_quiet <= 8'd0;
    else if (r_state != S_QUIET) r_quiet <= QUIET_LOAD;
    else if (r_quiet != 8'd0)    r_quiet <= r_quiet - 8'd1;
  end

  // Lead bits pass through the top of the shift register and fall off the end.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_sclk  <= 1'b1;
      r_bit   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last_rise;
      if (r_state != S_SHIFT) begin
        r_sclk <= 1'b1;
        r_bit  <= '0;
      end else if (w_tick) begin
        r_sclk <= ~r_sclk;
        if (!r_sclk) begin
          r_shift <= {r_shift[SAMPLE_BITS-2:0], adc_sdo};
          r_bit   <= w_last_rise ? '0 : r_bit + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      if (r_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_done && w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
      if (r_done && !w_load) r_overrun <= 1'b1;
      else if (clr_overrun)  r_overrun <= 1'b0;
    end
  end

  assign adc_sclk     = r_sclk;
  assign adc_cs_n     = w_cs_n;
  assign sample_data  = r_data;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign frame_count  = r_frame_cnt;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Self-checking bench for adc_serial_capture: default instance plus a HALF_DIV=1,
// QUIET_CYC=1 instance, each fed by a behavioural ADC that launches bits on SCLK falls.
module tb_adc_serial_capture;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0, capture_en = 1'b0, sample_ready = 1'b0, clr_overrun = 1'b0;
  logic        adc_sdo = 1'b0, adc_sclk, adc_cs_n, sample_valid, overrun;
  logic [11:0] sample_data;
  logic [15:0] frame_count;
  logic        capture_en1 = 1'b0, sample_ready1 = 1'b0;
  logic        adc_sdo1 = 1'b0, adc_sclk1, adc_cs_n1, sample_valid1, overrun1;
  logic [11:0] sample_data1;
  logic [15:0] frame_count1;

  always #10 CLOCK_50 = ~CLOCK_50;

  adc_serial_capture u_dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .capture_en(capture_en), .adc_sdo(adc_sdo),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun),
    .clr_overrun(clr_overrun), .frame_count(frame_count));

  adc_serial_capture #(.HALF_DIV(1), .QUIET_CYC(1)) u_dut1 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .capture_en(capture_en1), .adc_sdo(adc_sdo1),
    .adc_sclk(adc_sclk1), .adc_cs_n(adc_cs_n1), .sample_data(sample_data1),
    .sample_valid(sample_valid1), .sample_ready(sample_ready1), .overrun(overrun1),
    .clr_overrun(clr_overrun), .frame_count(frame_count1));

  typedef struct {
    logic [11:0] word;
    logic        ready;
    logic [11:0] exp_data;
    logic        exp_valid;
    logic        exp_ovr;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t        vecs [3];
  logic [11:0] words0 [10];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0;
  int          frm0 = 0, bit0 = 0, rises0 = 0, cslow0 = 0;
  int          bit1 = 0, rises1 = 0, cslow1 = 0, last_rise1 = 0, per1 = 0;
  logic [15:0] cur0 = '0, cur1 = '0;
  logic        prev_sclk0 = 1'b1, prev_cs0 = 1'b1, prev_sclk1 = 1'b1, prev_cs1 = 1'b1;

  // ADC models and edge monitors, evaluated mid-cycle.
  always @(negedge CLOCK_50) begin
    cyc++;
    if (prev_cs0 && !adc_cs_n) begin
      cur0 = (frm0 < 10) ? {4'h0, words0[frm0]} : 16'h0000;
      frm0++;
      bit0 = 0;
    end
    if (prev_sclk0 && !adc_sclk && !adc_cs_n && bit0 < 16) begin
      adc_sdo = cur0[15-bit0];
      bit0++;
    end
    if (!prev_sclk0 && adc_sclk) rises0++;
    if (!adc_cs_n) cslow0++;
    prev_sclk0 = adc_sclk;
    prev_cs0   = adc_cs_n;

    if (prev_cs1 && !adc_cs_n1) begin
      cur1 = {4'h0, 12'h5A5};
      bit1 = 0;
    end
    if (prev_sclk1 && !adc_sclk1 && !adc_cs_n1 && bit1 < 16) begin
      adc_sdo1 = cur1[15-bit1];
      bit1++;
    end
    if (!prev_sclk1 && adc_sclk1) begin
      rises1++;
      per1       = cyc - last_rise1;
      last_rise1 = cyc;
    end
    if (!adc_cs_n1) cslow1++;
    prev_sclk1 = adc_sclk1;
    prev_cs1   = adc_cs_n1;
  end

  task automatic step();
    @(negedge CLOCK_50);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cnt(input logic [15:0] tgt, input int budget, input string nm);
    int n = 0;
    while (frame_count !== tgt && n < budget) begin
      step();
      n++;
    end
    chk(nm, 32'(frame_count), 32'(tgt));
  endtask

  task automatic wait_rises(input int base, input int tgt, input int budget, input string nm);
    int n = 0;
    while ((rises0 - base) < tgt && n < budget) begin
      step();
      n++;
    end
    chk(nm, 32'(rises0 - base), 32'(tgt));
  endtask

  initial begin
    int          r_s, c_s, np, n;
    int          pv [3];
    logic [11:0] pd [3];

    vecs[0] = '{word: 12'hABC, ready: 1'b0, exp_data: 12'hABC, exp_valid: 1'b1, exp_ovr: 1'b0, exp_cnt: 16'd1};
    vecs[1] = '{word: 12'h123, ready: 1'b0, exp_data: 12'hABC, exp_valid: 1'b1, exp_ovr: 1'b1, exp_cnt: 16'd2};
    vecs[2] = '{word: 12'h456, ready: 1'b1, exp_data: 12'h456, exp_valid: 1'b0, exp_ovr: 1'b1, exp_cnt: 16'd3};
    for (int i = 0; i < 3; i++) words0[i] = vecs[i].word;
    words0[3] = 12'h001; words0[4] = 12'hFFF; words0[5] = 12'h800;
    words0[6] = 12'h123; words0[7] = 12'h456;
    words0[8] = 12'h2A7; words0[9] = 12'h3C3;

    // Reset and idle
    resetn = 1'b0;
    repeat (3) step();
    chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_sclk", 32'(adc_sclk), 32'd1);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_data", 32'(sample_data), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    resetn = 1'b1;
    r_s = rises0; c_s = cslow0;
    repeat (100) step();
    chk("idle_no_sclk", 32'(rises0 - r_s), 32'd0);
    chk("idle_cs_high", 32'(cslow0 - c_s), 32'd0);

    // Single frames from IDLE, one capture_en pulse each
    for (int i = 0; i < 3; i++) begin
      sample_ready = vecs[i].ready;
      r_s = rises0; c_s = cslow0;
      step(); capture_en = 1'b1;
      step(); capture_en = 1'b0;
      wait_cnt(vecs[i].exp_cnt, 200, $sformatf("vec%0d_count", i));
      repeat (10) step();
      chk($sformatf("vec%0d_data", i), 32'(sample_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_valid", i), 32'(sample_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].exp_ovr));
      chk($sformatf("vec%0d_rises", i), 32'(rises0 - r_s), 32'd16);
      chk($sformatf("vec%0d_cs_low", i), 32'(cslow0 - c_s), 32'd66);
    end
    sample_ready = 1'b0;
    step(); clr_overrun = 1'b1;
    step(); clr_overrun = 1'b0;
    chk("clr_ovr_a", 32'(overrun), 32'd0);

    // Back-to-back frames with ready held high
    sample_ready = 1'b1;
    capture_en   = 1'b1;
    np = 0; n = 0;
    while (np < 3 && n < 400) begin
      step();
      n++;
      if (sample_valid) begin
        pv[np] = cyc;
        pd[np] = sample_data;
        np++;
        if (np == 3) capture_en = 1'b0;
      end
    end
    capture_en = 1'b0;
    chk("b2b_pulses", 32'(np), 32'd3);
    if (np == 3) begin
      chk("b2b_data0", 32'(pd[0]), 32'h001);
      chk("b2b_data1", 32'(pd[1]), 32'hFFF);
      chk("b2b_data2", 32'(pd[2]), 32'h800);
      chk("b2b_gap01", 32'(pv[1] - pv[0]), 32'd70);
      chk("b2b_gap12", 32'(pv[2] - pv[1]), 32'd70);
    end
    repeat (10) step();
    chk("b2b_ovr", 32'(overrun), 32'd0);
    chk("b2b_idle", 32'(adc_cs_n), 32'd1);
    chk("b2b_count", 32'(frame_count), 32'd6);
    sample_ready = 1'b0;

    // Overrun with ready low across two frames
    capture_en = 1'b1;
    wait_cnt(16'd8, 300, "ovr_count");
    capture_en = 1'b0;
    repeat (10) step();
    chk("ovr_data", 32'(sample_data), 32'h123);
    chk("ovr_valid", 32'(sample_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    step(); clr_overrun = 1'b1;
    step(); clr_overrun = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    sample_ready = 1'b1;
    step(); sample_ready = 1'b0;
    chk("ovr_accept", 32'(sample_valid), 32'd0);
    chk("ovr_data_hold", 32'(sample_data), 32'h123);

    // capture_en dropped at bit 5: frame still completes, then IDLE
    r_s = rises0;
    step(); capture_en = 1'b1;
    wait_rises(r_s, 5, 200, "mid_bit5");
    capture_en = 1'b0;
    wait_cnt(16'd9, 200, "mid_count");
    repeat (20) step();
    chk("mid_data", 32'(sample_data), 32'h2A7);
    chk("mid_valid", 32'(sample_valid), 32'd1);
    chk("mid_idle", 32'(adc_cs_n), 32'd1);
    chk("mid_rises", 32'(rises0 - r_s), 32'd16);
    chk("mid_no_more", 32'(frame_count), 32'd9);

    // Reset asserted at bit 8 aborts the frame
    r_s = rises0;
    step(); capture_en = 1'b1;
    step(); capture_en = 1'b0;
    wait_rises(r_s, 8, 200, "rst8_bit8");
    n = 0;
    while (adc_sclk && n < 10) begin
      step();
      n++;
    end
    chk("rst8_sclk_low", 32'(adc_sclk), 32'd0);
    resetn = 1'b0;
    step();
    chk("rst8_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst8_sclk", 32'(adc_sclk), 32'd1);
    chk("rst8_valid", 32'(sample_valid), 32'd0);
    chk("rst8_count", 32'(frame_count), 32'd0);
    resetn = 1'b1;
    repeat (100) step();
    chk("rst8_no_sample", 32'(sample_valid), 32'd0);
    chk("rst8_count_hold", 32'(frame_count), 32'd0);

    // HALF_DIV=1, QUIET_CYC=1 instance, frame counter wrap
    force u_dut1.r_frame_cnt = 16'hFFFF;
    step();
    release u_dut1.r_frame_cnt;
    step();
    chk("fast_preload", 32'(frame_count1), 32'hFFFF);
    r_s = rises1; c_s = cslow1;
    step(); capture_en1 = 1'b1;
    step(); capture_en1 = 1'b0;
    n = 0;
    while (frame_count1 === 16'hFFFF && n < 100) begin
      step();
      n++;
    end
    chk("fast_wrap", 32'(frame_count1), 32'd0);
    chk("fast_data", 32'(sample_data1), 32'h5A5);
    chk("fast_valid", 32'(sample_valid1), 32'd1);
    repeat (5) step();
    chk("fast_rises", 32'(rises1 - r_s), 32'd16);
    chk("fast_cs_low", 32'(cslow1 - c_s), 32'd33);
    chk("fast_sclk_period", 32'(per1), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
